dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//  MEM-stage load/store engine: the consumer of the EX/MEM pipeline register outputs.
//  Issues one data-memory request per load/store over a valid/ready request channel.
//  Drives the stall back into EX/MEM and formats load data for MEM/WB.
//  Sits between EX/MEM and the DCache/data bus.
// PARAMETERS
//  WORD    32  data/address width (from CPU_Parameter.vh)
//  STRB_W  4   byte strobes, WORD/8
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  is_dmem      in   2      from EX/MEM: 00 none, 01 load, 10 store, 11 treated as none
//  mem_addr     in   WORD   effective address (ALU result)
//  mem_wdata    in   WORD   store data, right-aligned
//  mem_size     in   2      00 byte, 01 half, 10 word, 11 treated as word
//  mem_sign     in   1      1 = sign-extend load, 0 = zero-extend
//  stall        out  1      to EX_MEM_stall_from_DCache; holds EX/MEM while access is pending
//  ld_data      out  WORD   extended load result; valid only while ld_valid
//  ld_valid     out  1      1-cycle pulse: load completed
//  misalign     out  1      1-cycle pulse: misaligned access, no bus request issued
//  req_valid    out  1      bus request valid
//  req_ready    in   1      bus accepts request
//  req_we       out  1      1 = store
//  req_addr     out  WORD   word-aligned address {addr[31:2],2'b00}
//  req_wstrb    out  STRB_W byte enables (0 for loads)
//  req_wdata    out  WORD   lane-replicated store data
//  resp_valid   in   1      read data / write ack valid
//  resp_rdata   in   WORD   raw read word
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE. req_valid, ld_valid, misalign and stall all 0.
//    req_* payload and ld_data are 0. Any in-flight bus transaction is abandoned.
//  FSM states: IDLE, REQ, RESP, DONE.
//  IDLE: access = is_dmem in {01,10}.
//    aligned access -> capture addr/size/sign/we/strb/wdata, go REQ.
//    misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> misalign=1 for 1 cycle, stay IDLE.
//  REQ: req_valid=1 with a stable registered payload.
//    req_valid && req_ready -> go RESP.
//  RESP: resp_valid -> latch the formatted load data, go DONE.
//    resp_valid is ignored in IDLE/REQ/DONE; the bus never responds in the handshake cycle.
//  DONE: ld_valid=1 for a load (0 for a store), stall=0; EX/MEM advances on this edge; go IDLE.
//  stall (combinational) = (IDLE && aligned access) | REQ | RESP. It is 0 in DONE and on misalign.
//  Latency: minimum 3 cycles from access presented to DONE (IDLE->REQ->RESP->DONE with zero-wait bus).
//  wstrb: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
//  wdata: byte {4{b}}, half {2{h}}, word unchanged.
//  Load: sh = resp_rdata >> (8*addr[1:0]); take low 8/16/32 bits; extend per mem_sign to WORD.
//  EX/MEM content changes only after DONE or misalign, so an access is never re-issued.
//  Back-to-back accesses: IDLE is re-entered after DONE, so a new access starts every >=4 cycles.
// STRUCTURE
//  CPU_Parameter.vh: WORD plus new defines DMEM_NONE/DMEM_LOAD/DMEM_STORE and SIZE_B/SIZE_H/SIZE_W.
//    State encodings are local parameters.
//  One combinational sub-module, dmem_lane_align: strb/wdata generation and load extract/extend.
//  FSM, payload registers and stall logic live in the top module.
// TESTING
//  1 Word load, addr 0x1000_0004, zero-wait bus, rdata 0xDEADBEEF:
//    req_addr 0x1000_0004, wstrb 0; stall high 3 cycles; ld_valid with ld_data 0xDEADBEEF in DONE.
//  2 Signed byte load, addr ..0003, rdata 0x80FF_0000:
//    ld_data 0xFFFF_FF80. Same access unsigned -> 0x0000_0080.
//  3 Half store, addr ..0002, wdata 0x0000_1234:
//    wstrb 4'b1100, req_wdata 0x1234_1234, req_we 1; ld_valid stays 0.
//  4 Word load, addr ..0001: misalign pulses, req_valid never asserts, stall stays 0.
//  5 req_ready low 5 cycles, then resp delayed 3 cycles:
//    payload stable throughout; stall held through RESP; single request only.
//  6 rst_n low while in RESP: outputs zero immediately; a late resp_valid after reset is ignored.

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// Shared widths, opcode/size encodings, FSM states and request payload for the MEM-stage access unit.
package dmem_access_unit_pkg;

    localparam int unsigned WORD   = 32;
    localparam int unsigned STRB_W = WORD / 8;

    // is_dmem encodings from EX/MEM (2'b11 is treated as no access)
    localparam logic [1:0] DMEM_NONE  = 2'b00;
    localparam logic [1:0] DMEM_LOAD  = 2'b01;
    localparam logic [1:0] DMEM_STORE = 2'b10;

    // mem_size encodings (2'b11 is treated as a word)
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Registered bus request payload, held stable while the request is pending
    typedef struct packed {
        logic              we;
        logic [WORD-1:0]   addr;
        logic [STRB_W-1:0] wstrb;
        logic [WORD-1:0]   wdata;
    } req_t;

    // Halfwords need an even address, words need a 4-byte aligned address
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_access_unit_lane_align.sv
// Byte-lane formatting: store strobes/replicated data and load extract/extend.
module dmem_lane_align
    import dmem_access_unit_pkg::*;
(
    input  logic [1:0]        st_off,
    input  logic [1:0]        st_size,
    input  logic [WORD-1:0]   st_data,
    output logic [STRB_W-1:0] st_strb_c,
    output logic [WORD-1:0]   st_data_c,
    input  logic [1:0]        ld_off,
    input  logic [1:0]        ld_size,
    input  logic              ld_sign,
    input  logic [WORD-1:0]   ld_raw,
    output logic [WORD-1:0]   ld_data_c
);

    logic [WORD-1:0] sh;

    // Store side: strobes follow the byte offset, data is replicated into every lane
    always_comb begin
        st_strb_c = {STRB_W{1'b1}};
        st_data_c = st_data;
        case (st_size)
            SIZE_B: begin
                st_strb_c = STRB_W'(1) << st_off;
                st_data_c = {(WORD/8){st_data[7:0]}};
            end
            SIZE_H: begin
                st_strb_c = STRB_W'(3) << st_off;
                st_data_c = {(WORD/16){st_data[15:0]}};
            end
            default: begin
                st_strb_c = {STRB_W{1'b1}};
                st_data_c = st_data;
            end
        endcase
    end

    // Load side: shift the addressed bytes down, then sign- or zero-extend
    always_comb begin
        sh        = ld_raw >> {ld_off, 3'b000};
        ld_data_c = sh;
        case (ld_size)
            SIZE_B:  ld_data_c = {{(WORD-8){ld_sign & sh[7]}}, sh[7:0]};
            SIZE_H:  ld_data_c = {{(WORD-16){ld_sign & sh[15]}}, sh[15:0]};
            default: ld_data_c = sh;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store engine: one bus request per access, stall to EX/MEM, formatted load data.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        is_dmem,
    input  logic [WORD-1:0]   mem_addr,
    input  logic [WORD-1:0]   mem_wdata,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    output logic              stall,
    output logic [WORD-1:0]   ld_data,
    output logic              ld_valid,
    output logic              misalign,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [WORD-1:0]   req_addr,
    output logic [STRB_W-1:0] req_wstrb,
    output logic [WORD-1:0]   req_wdata,
    input  logic              resp_valid,
    input  logic [WORD-1:0]   resp_rdata
);

    state_e            state;
    req_t              req_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              sign_q;

    logic              access_c;
    logic              mis_c;
    logic [STRB_W-1:0] strb_c;
    logic [WORD-1:0]   wdata_c;
    logic [WORD-1:0]   ld_fmt_c;

    assign access_c = (is_dmem == DMEM_LOAD) || (is_dmem == DMEM_STORE);
    assign mis_c    = is_misaligned(mem_size, mem_addr[1:0]);

    dmem_lane_align u_lane_align (
        .st_off    (mem_addr[1:0]),
        .st_size   (mem_size),
        .st_data   (mem_wdata),
        .st_strb_c (strb_c),
        .st_data_c (wdata_c),
        .ld_off    (off_q),
        .ld_size   (size_q),
        .ld_sign   (sign_q),
        .ld_raw    (resp_rdata),
        .ld_data_c (ld_fmt_c)
    );

    // Hold EX/MEM from the cycle an aligned access is seen until the response arrives
    assign stall = ((state == ST_IDLE) && access_c && !mis_c)
                 || (state == ST_REQ) || (state == ST_RESP);

    assign req_we    = req_q.we;
    assign req_addr  = req_q.addr;
    assign req_wstrb = req_q.wstrb;
    assign req_wdata = req_q.wdata;

    // Access FSM with registered request payload and result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            sign_q    <= 1'b0;
            req_valid <= 1'b0;
            ld_valid  <= 1'b0;
            ld_data   <= '0;
            misalign  <= 1'b0;
        end else begin
            ld_valid <= 1'b0;
            misalign <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access_c) begin
                        if (mis_c) begin
                            misalign <= 1'b1;
                        end else begin
                            req_q.we    <= (is_dmem == DMEM_STORE);
                            req_q.addr  <= {mem_addr[WORD-1:2], 2'b00};
                            req_q.wstrb <= (is_dmem == DMEM_STORE) ? strb_c : '0;
                            req_q.wdata <= (is_dmem == DMEM_STORE) ? wdata_c : '0;
                            off_q       <= mem_addr[1:0];
                            size_q      <= mem_size;
                            sign_q      <= mem_sign;
                            req_valid   <= 1'b1;
                            state       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_valid) begin
                        ld_data  <= ld_fmt_c;
                        ld_valid <= !req_q.we;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed accesses against a byte-lane transaction model.
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  is_dmem;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    dmem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .is_dmem    (is_dmem),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_size   (mem_size),
        .mem_sign   (mem_sign),
        .stall      (stall),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .misalign   (misalign),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wstrb  (req_wstrb),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model expectations for the access currently presented
    logic        exp_acc, exp_mis, exp_we, exp_is_load;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_strb;

    // Observations from the last run_access
    int          stall_cnt, reqc, hsn, lds, mis;
    logic [31:0] got_ld, got_addr, got_wdata;
    logic [3:0]  got_strb;
    logic        got_we;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    // Transaction model: lanes as byte arrays, extension by two's-complement arithmetic
    task automatic model_calc(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic sign, input logic [31:0] rdata);
        int n;
        int off;
        logic [31:0] sh;
        logic [31:0] mask;
        n           = nbytes_of(size);
        off         = int'(addr % 32'd4);
        exp_acc     = (op == 2'b01) || (op == 2'b10);
        exp_is_load = (op == 2'b01);
        exp_we      = (op == 2'b10);
        exp_mis     = exp_acc && ((addr % 32'(n)) != 32'd0);
        exp_addr    = addr & 32'hFFFF_FFFC;
        exp_strb    = exp_we ? 4'(((1 << n) - 1) << off) : 4'h0;
        exp_wdata   = 32'h0;
        for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
        sh = rdata >> (8 * off);
        if (n == 4) begin
            exp_ld = sh;
        end else begin
            mask   = (32'd1 << (8 * n)) - 32'd1;
            exp_ld = sh & mask;
            if (sign && exp_ld[8*n-1]) exp_ld = exp_ld - (32'd1 << (8 * n));
        end
    endtask

    // Per-cycle compare of bus payload and load results against the model
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid) begin
                chk("req_we", 32'(req_we), 32'(exp_we));
                chk("req_addr", req_addr, exp_addr);
                chk("req_wstrb", 32'(req_wstrb), 32'(exp_strb));
                if (exp_we) chk("req_wdata", req_wdata, exp_wdata);
                chk("req_without_misalign", 32'(req_valid), 32'(!exp_mis && exp_acc));
            end
            if (ld_valid) begin
                chk("ld_valid_on_load", 32'(ld_valid), 32'(exp_is_load));
                chk("ld_data", ld_data, exp_ld);
            end
            if (misalign) chk("misalign_expected", 32'(misalign), 32'(exp_mis));
        end
    end

    // Present one access, play a bus with the given wait states, and let EX/MEM advance when stall drops
    task automatic run_access(input string tag, input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic sign,
                              input int rdy_dly, input int resp_dly, input logic [31:0] rdata);
        logic hs, sent, done, hs_now, rv_now, adv;
        int   wt;
        model_calc(op, addr, wdata, size, sign, rdata);
        is_dmem    = op;
        mem_addr   = addr;
        mem_wdata  = wdata;
        mem_size   = size;
        mem_sign   = sign;
        resp_rdata = rdata;
        stall_cnt = 0; reqc = 0; hsn = 0; lds = 0; mis = 0; wt = 0;
        hs = 1'b0; sent = 1'b0; done = 1'b0;
        got_ld = 32'h0; got_addr = 32'h0; got_wdata = 32'h0; got_strb = 4'h0; got_we = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            req_ready  = req_valid && (reqc >= rdy_dly);
            resp_valid = hs && !sent && (wt == resp_dly);
            #1;
            if (stall) stall_cnt++;
            if (req_valid) begin
                if (reqc == 0) begin
                    got_addr = req_addr; got_strb = req_wstrb; got_wdata = req_wdata; got_we = req_we;
                end
                reqc++;
            end
            if (ld_valid) begin lds++; got_ld = ld_data; end
            if (misalign) mis++;
            hs_now = req_valid && req_ready;
            rv_now = resp_valid;
            adv    = !stall;
            @(posedge clk); #1;
            if (rv_now) sent = 1'b1;
            if (hs_now) begin hs = 1'b1; hsn++; end
            else if (hs && !sent) wt++;
            if (adv) done = 1'b1;
        end
        chk({tag, "_completes"}, 32'(done), 32'd1);
        is_dmem    = DMEM_NONE;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (ld_valid) lds++;
            if (misalign) mis++;
            if (req_valid) reqc++;
            if (stall) stall_cnt++;
            @(posedge clk); #1;
        end
        chk({tag, "_stall_cycles"}, 32'(stall_cnt),
            (exp_acc && !exp_mis) ? 32'(3 + rdy_dly + resp_dly) : 32'd0);
        chk({tag, "_req_cycles"}, 32'(reqc), (exp_acc && !exp_mis) ? 32'(rdy_dly + 1) : 32'd0);
        chk({tag, "_handshakes"}, 32'(hsn), (exp_acc && !exp_mis) ? 32'd1 : 32'd0);
        chk({tag, "_ld_pulses"}, 32'(lds), (exp_is_load && !exp_mis) ? 32'd1 : 32'd0);
        chk({tag, "_mis_pulses"}, 32'(mis), 32'(exp_mis));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_valid"}, 32'(req_valid), 32'd0);
        chk({tag, "_ld_valid"}, 32'(ld_valid), 32'd0);
        chk({tag, "_misalign"}, 32'(misalign), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_req_we"}, 32'(req_we), 32'd0);
        chk({tag, "_req_addr"}, req_addr, 32'd0);
        chk({tag, "_req_wstrb"}, 32'(req_wstrb), 32'd0);
        chk({tag, "_req_wdata"}, req_wdata, 32'd0);
        chk({tag, "_ld_data"}, ld_data, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; is_dmem = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0; mem_size = 2'b00;
        mem_sign = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'h0;
        model_calc(2'b00, 32'h0, 32'h0, 2'b10, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: word load, zero-wait bus
        run_access("t1_word_load", 2'b01, 32'h1000_0004, 32'h0, 2'b10, 1'b0, 0, 0, 32'hDEAD_BEEF);
        chk("t1_model_ld", exp_ld, 32'hDEAD_BEEF);
        chk("t1_ld_data", got_ld, 32'hDEAD_BEEF);
        chk("t1_req_addr", got_addr, 32'h1000_0004);
        chk("t1_wstrb", 32'(got_strb), 32'h0);
        chk("t1_stall3", 32'(stall_cnt), 32'd3);

        // 2: byte load at offset 3, signed then unsigned
        run_access("t2_sbyte", 2'b01, 32'h1000_0003, 32'h0, 2'b00, 1'b1, 0, 0, 32'h80FF_0000);
        chk("t2_signed_ld", got_ld, 32'hFFFF_FF80);
        chk("t2_req_addr", got_addr, 32'h1000_0000);
        run_access("t2_ubyte", 2'b01, 32'h1000_0003, 32'h0, 2'b00, 1'b0, 0, 0, 32'h80FF_0000);
        chk("t2_unsigned_ld", got_ld, 32'h0000_0080);

        // 3: half store at offset 2
        run_access("t3_hstore", 2'b10, 32'h1000_0002, 32'h0000_1234, 2'b01, 1'b0, 0, 0, 32'h0);
        chk("t3_wstrb", 32'(got_strb), 32'hC);
        chk("t3_wdata", got_wdata, 32'h1234_1234);
        chk("t3_we", 32'(got_we), 32'd1);
        chk("t3_no_ld_valid", 32'(lds), 32'd0);

        // 4: misaligned word load
        run_access("t4_mis_word", 2'b01, 32'h1000_0001, 32'h0, 2'b10, 1'b0, 0, 0, 32'h0);
        chk("t4_mis_pulse", 32'(mis), 32'd1);
        chk("t4_no_req", 32'(reqc), 32'd0);
        chk("t4_no_stall", 32'(stall_cnt), 32'd0);

        // 5: slow bus, store word
        run_access("t5_slow", 2'b10, 32'h2000_0008, 32'hA5A5_5A5A, 2'b10, 1'b0, 5, 3, 32'h0);
        chk("t5_stall11", 32'(stall_cnt), 32'd11);
        chk("t5_req_cycles6", 32'(reqc), 32'd6);
        chk("t5_wstrb", 32'(got_strb), 32'hF);

        // Further lane and boundary cases
        run_access("bstore_off1", 2'b10, 32'h0000_0041, 32'h0000_00C3, 2'b00, 1'b0, 1, 0, 32'h0);
        chk("bstore_off1_strb", 32'(got_strb), 32'h2);
        chk("bstore_off1_wdata", got_wdata, 32'hC3C3_C3C3);
        run_access("hload_s_off2", 2'b01, 32'h0000_0082, 32'h0, 2'b01, 1'b1, 0, 2, 32'h8001_7FFF);
        chk("hload_s_off2_ld", got_ld, 32'hFFFF_8001);
        run_access("hload_u_off0", 2'b01, 32'h0000_0080, 32'h0, 2'b01, 1'b0, 2, 1, 32'h8001_F00D);
        chk("hload_u_off0_ld", got_ld, 32'h0000_F00D);
        run_access("hload_mis", 2'b01, 32'h0000_0083, 32'h0, 2'b01, 1'b1, 0, 0, 32'h0);
        run_access("size11_load", 2'b01, 32'h0000_00F0, 32'h0, 2'b11, 1'b1, 0, 0, 32'h1357_9BDF);
        run_access("size11_mis", 2'b10, 32'h0000_00F2, 32'h0, 2'b11, 1'b0, 0, 0, 32'h0);
        run_access("op11_none", 2'b11, 32'h0000_0001, 32'h0, 2'b10, 1'b0, 0, 0, 32'h0);
        run_access("op00_none", 2'b00, 32'h0000_0010, 32'h0, 2'b10, 1'b0, 0, 0, 32'h0);
        run_access("bstore_off3", 2'b10, 32'h0000_0107, 32'h1234_5678, 2'b00, 1'b0, 0, 0, 32'h0);
        chk("bstore_off3_strb", 32'(got_strb), 32'h8);

        // 6: reset while waiting for the response
        model_calc(2'b01, 32'h3000_0010, 32'h0, 2'b10, 1'b0, 32'h0BAD_F00D);
        is_dmem = 2'b01; mem_addr = 32'h3000_0010; mem_size = 2'b10; mem_sign = 1'b0;
        resp_rdata = 32'h0BAD_F00D; req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_in_resp_stall", 32'(stall), 32'd1);
        chk("t6_in_resp_req_valid", 32'(req_valid), 32'd0);
        #2;
        rst_n = 1'b0; is_dmem = 2'b00; req_ready = 1'b0;
        #1;
        chk_all_zero("t6_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t6_late_ld_valid", 32'(ld_valid), 32'd0);
            chk("t6_late_stall", 32'(stall), 32'd0);
            chk("t6_late_req_valid", 32'(req_valid), 32'd0);
            @(posedge clk); #1;
            resp_valid = (c == 0);
        end
        resp_valid = 1'b0;

        run_access("t6_recover", 2'b01, 32'h3000_0014, 32'h0, 2'b10, 1'b0, 0, 0, 32'hCAFE_0001);
        chk("t6_recover_ld", got_ld, 32'hCAFE_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
